prog_mealy_fsm: RTL and testbench
=================================

Name: prog_mealy_fsm

Overview:
Parametrised, table-driven Mealy state machine with a 1-bit serial input, and the programmable successor to our fixed-table 5-state exercise FSMs. The next-state and output tables are held in registers and rewritten at run time through a config write port, so a single block serves any serial-input controller of up to NUM_STATES states. It sits between a serial bit source and downstream logic that consumes the per-cycle Mealy output.

Parameters:
NUM_STATES, 8, number of legal states (2..256); states are encoded 0..NUM_STATES-1.
OUT_W, 1, width of the output word stored per table entry.
RESET_STATE, 0, state entered on reset; must be < NUM_STATES.
STATE_W, $clog2(NUM_STATES), localparam; state encoding width.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk
in  input  1  serial input bit
en  input  1  advance enable; when 0, state holds and out is forced to 0
out  output  OUT_W  Mealy output, out_tbl[{state,in}] when en=1
state  output  STATE_W  current state register
cfg_we  input  1  table write strobe
cfg_addr  input  STATE_W+1  entry address {state_field, in_bit}
cfg_next  input  STATE_W  next-state value to write
cfg_out  input  OUT_W  output value to write
cfg_err  output  1  registered, 1-cycle pulse on a rejected write

Behaviour:
- Reset (reset=0 at a clk edge): state<=RESET_STATE; cfg_err<=0; both tables load the default program. reset overrides cfg_we and en.
- Default program, for every s: entry {s,0}: next=s, out=0. Entry {s,1}: next=(s+1) mod NUM_STATES; out=1 (LSB set, other bits 0) only when s==NUM_STATES-1, else 0. The default therefore pulses out on every NUM_STATES-th '1'.
- Output is combinational from state, in and en, with zero latency: out=en ? out_tbl[{state,in}] : 0.
- Transition: on a rising edge with reset=1 and en=1, state<=next_tbl[{state,in}]. With en=0, state holds.
- Config write: on a rising edge with cfg_we=1, both entries at cfg_addr are written. The new values take effect from the next cycle.
- Simultaneous write and use of the same entry: the current transition and output use the old contents.
- Write rejection: the write is dropped (table unchanged) and cfg_err=1 for exactly the next cycle when either cfg_next>=NUM_STATES or cfg_addr[STATE_W:1]>=NUM_STATES. Both checks are needed only when NUM_STATES is not a power of 2.
- Invariant: state is always < NUM_STATES. No illegal state is reachable through any combination of writes.
- Reset mid-program: all prior writes are lost and the default program is restored.
- Writes are permitted while en=1; no stall or handshake is required.

Optional Feature:
Macro PROG_MEALY_REG_OUT_EN.
- Defined: out is registered. out<=(en ? out_tbl[{state,in}] : 0) on each edge, giving one cycle of latency. Reset value of out is 0.
- Not defined: out is combinational Mealy, as described above.
- State timing is identical in both builds.

Decomposition:
- Package prog_mealy_pkg: the default-program function default_next(s,b,N) and default_out(s,b,N), and the cfg error-code constant.
- Sub-module prog_mealy_tbl: the 2*NUM_STATES entry register table, containing the write port, range check, cfg_err generation and reset-to-default loading. It exposes one combinational read port {state,in} -> {next,out}.
- The top level holds the state register, the en gating and the optional output register.

Test Plan:
1. NUM_STATES=5, default program, en=1, reset pulse then in=1 for 10 cycles -> state sequence 0,1,2,3,4,0,1,2,3,4; out=1 exactly when state==4 and in==1, i.e. 2 pulses.
2. in=0 for 4 cycles from state 2 -> state stays 2, out=0 throughout. Then en=0 with in=1 for 3 cycles -> state stays 2, out=0.
3. Write {addr={3,1}, next=0, out=1}, then drive in=1 from state 0 -> path 0,1,2,3,0, with out=1 at state 3. Write in the same cycle that state==3 and in==1 -> that transition goes to 4 (old entry), and the new entry is used afterwards.
4. NUM_STATES=5: write cfg_next=6, then cfg_addr state field 7 -> both rejected, cfg_err high for one cycle each, table and state unchanged.
5. After reprogramming, assert reset=0 mid-sequence for one edge -> state=0 on that edge, default program restored (repeat scenario 1 and check it passes); cfg_err=0.
6. Build with PROG_MEALY_REG_OUT_EN, rerun scenario 1 -> identical state trace, out pulses delayed by one cycle, out=0 after reset.

Source files
------------

// File: rtl/prog_mealy_pkg.sv
// Shared definitions for the programmable Mealy FSM: default program and cfg status codes.
package prog_mealy_pkg;

  typedef enum logic {
    CFG_OK        = 1'b0,
    CFG_ERR_RANGE = 1'b1
  } cfg_status_e;

  // Default program: hold on '0', count on '1', pulse on the wrap from the last state.
  function automatic int default_next(input int s, input int b, input int n);
    return (b != 0) ? ((s + 1) % n) : s;
  endfunction

  function automatic int default_out(input int s, input int b, input int n);
    return ((b != 0) && (s == n - 1)) ? 1 : 0;
  endfunction

endpackage

// File: rtl/prog_mealy_tbl.sv
// Register table of 2*NUM_STATES {next,out} entries with a range-checked write port
// and one combinational read port addressed by {state,in}.
module prog_mealy_tbl
  import prog_mealy_pkg::*;
#(
  parameter int NUM_STATES = 8,
  parameter int OUT_W      = 1,
  parameter int STATE_W    = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [STATE_W:0]   wr_addr,
  input  logic [STATE_W-1:0] wr_next,
  input  logic [OUT_W-1:0]   wr_out,
  input  logic [STATE_W:0]   rd_addr,
  output logic [STATE_W-1:0] rd_next,
  output logic [OUT_W-1:0]   rd_out,
  output logic               err
);

  localparam int ENTRIES = 2 * NUM_STATES;
  localparam logic [STATE_W:0] LIMIT = (STATE_W+1)'(NUM_STATES);

  logic [STATE_W-1:0] next_tbl [ENTRIES];
  logic [OUT_W-1:0]   out_tbl  [ENTRIES];
  cfg_status_e        status;

  // Rejecting bad next values keeps every reachable state below NUM_STATES.
  always_comb begin
    status = CFG_OK;
    if (({1'b0, wr_next} >= LIMIT) || ({1'b0, wr_addr[STATE_W:1]} >= LIMIT))
      status = CFG_ERR_RANGE;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        next_tbl[i] <= STATE_W'(default_next(i / 2, i % 2, NUM_STATES));
        out_tbl[i]  <= OUT_W'(default_out(i / 2, i % 2, NUM_STATES));
      end
      err <= 1'b0;
    end else begin
      err <= we && (status == CFG_ERR_RANGE);
      if (we && (status == CFG_OK)) begin
        next_tbl[wr_addr] <= wr_next;
        out_tbl[wr_addr]  <= wr_out;
      end
    end
  end

  assign rd_next = next_tbl[rd_addr];
  assign rd_out  = out_tbl[rd_addr];

endmodule

// File: rtl/prog_mealy_fsm.sv
// Table-driven Mealy FSM with a 1-bit serial input and run-time programmable tables.
// Define PROG_MEALY_REG_OUT_EN to register out (one cycle of latency).
module prog_mealy_fsm
  import prog_mealy_pkg::*;
#(
  parameter  int NUM_STATES  = 8,
  parameter  int OUT_W       = 1,
  parameter  int RESET_STATE = 0,
  localparam int STATE_W     = $clog2(NUM_STATES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               en,
  output logic [OUT_W-1:0]   out,
  output logic [STATE_W-1:0] state,
  input  logic               cfg_we,
  input  logic [STATE_W:0]   cfg_addr,
  input  logic [STATE_W-1:0] cfg_next,
  input  logic [OUT_W-1:0]   cfg_out,
  output logic               cfg_err
);

  logic [STATE_W-1:0] tbl_next;
  logic [OUT_W-1:0]   tbl_out;
  logic [OUT_W-1:0]   mealy_out;

  prog_mealy_tbl #(
    .NUM_STATES(NUM_STATES),
    .OUT_W     (OUT_W),
    .STATE_W   (STATE_W)
  ) u_tbl (
    .clk    (clk),
    .reset  (reset),
    .we     (cfg_we),
    .wr_addr(cfg_addr),
    .wr_next(cfg_next),
    .wr_out (cfg_out),
    .rd_addr({state, in}),
    .rd_next(tbl_next),
    .rd_out (tbl_out),
    .err    (cfg_err)
  );

  assign mealy_out = en ? tbl_out : '0;

  always_ff @(posedge clk) begin
    if (!reset)  state <= STATE_W'(RESET_STATE);
    else if (en) state <= tbl_next;
  end

`ifdef PROG_MEALY_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (!reset) out <= '0;
    else        out <= mealy_out;
  end
`else
  assign out = mealy_out;
`endif

endmodule

// File: tb/tb_prog_mealy_fsm.sv
// Directed bench for prog_mealy_fsm with NUM_STATES=5; handles both output builds.
module tb_prog_mealy_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_b = 1'b0;
  logic       en = 1'b0;
  logic [0:0] out;
  logic [2:0] state;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [2:0] cfg_next = '0;
  logic [0:0] cfg_out = '0;
  logic       cfg_err;

  int n_chk  = 0;
  int n_fail = 0;
  int prev_out = -1;

  always #5 clk = ~clk;

  prog_mealy_fsm #(.NUM_STATES(5), .OUT_W(1), .RESET_STATE(0)) dut (
    .clk     (clk),
    .reset   (reset),
    .in      (in_b),
    .en      (en),
    .out     (out),
    .state   (state),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_next(cfg_next),
    .cfg_out (cfg_out),
    .cfg_err (cfg_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check out before the edge, state/cfg_err after it.
  // eo is the combinational Mealy expectation for this cycle (-1 = don't check).
  task automatic cyc(input string tag, input logic r, input logic i, input logic e,
                     input logic w, input int a, input int nx, input int co,
                     input int eo, input int es, input int ee);
    int exp_o;
    @(negedge clk);
    reset = r; in_b = i; en = e; cfg_we = w;
    cfg_addr = 4'(a); cfg_next = 3'(nx); cfg_out = 1'(co);
    #1;
`ifdef PROG_MEALY_REG_OUT_EN
    exp_o = prev_out;
`else
    exp_o = eo;
`endif
    if (exp_o >= 0) chk({tag, ".out"}, int'(out), exp_o);
    @(posedge clk);
    #1;
    chk({tag, ".state"}, int'(state), es);
    chk({tag, ".err"}, int'(cfg_err), ee);
    prev_out = r ? eo : 0;
  endtask

  task automatic run1(input string tag);
    // state trace 0,1,2,3,4,0,1,2,3,4 with in=1; pulses leaving state 4
    for (int k = 0; k < 10; k++)
      cyc(tag, 1, 1, 1, 0, 0, 0, 0, ((k % 5) == 4) ? 1 : 0, (k + 1) % 5, 0);
  endtask

  initial begin
    // reset
    cyc("rst", 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
    cyc("idle", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // 1: default counter
    run1("s1");
    cyc("s1b", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("s1c", 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);

    // 2: in=0 holds, en=0 holds with out forced low
    for (int k = 0; k < 4; k++) cyc("s2hold", 1, 0, 1, 0, 0, 0, 0, 0, 2, 0);
    for (int k = 0; k < 3; k++) cyc("s2en0", 1, 1, 0, 0, 0, 0, 0, 0, 2, 0);

    // back to 0
    cyc("s3pre", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    cyc("s3pre", 1, 1, 1, 0, 0, 0, 0, 0, 4, 0);
    cyc("s3pre", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);

    // 3: {3,1} -> next 0, out 1
    cyc("s3wr", 1, 0, 0, 1, 7, 0, 1, 0, 0, 0);
    cyc("s3a", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("s3a", 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    cyc("s3a", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    cyc("s3a", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    // restore default entry, then rewrite it while it is in use
    cyc("s3rst", 1, 0, 0, 1, 7, 4, 0, 0, 0, 0);
    cyc("s3b", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("s3b", 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    cyc("s3b", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    cyc("s3same", 1, 1, 1, 1, 7, 0, 1, 0, 4, 0);
    cyc("s3b", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
    cyc("s3c", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);
    cyc("s3c", 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    cyc("s3c", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    cyc("s3new", 1, 1, 1, 0, 0, 0, 0, 1, 0, 0);

    // 4: rejected writes (next=6, next=5, state field 7)
    cyc("s4n6", 1, 0, 0, 1, 1, 6, 1, 0, 0, 1);
    cyc("s4gap", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("s4n5", 1, 0, 0, 1, 1, 5, 1, 0, 0, 1);
    cyc("s4gap", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("s4a7", 1, 0, 0, 1, 15, 0, 1, 0, 0, 1);
    cyc("s4gap", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc("s4tbl", 1, 1, 1, 0, 0, 0, 0, 0, 1, 0);

    // 5: reset mid-sequence at reprogrammed state 3, with a write that must be dropped
    cyc("s5", 1, 1, 1, 0, 0, 0, 0, 0, 2, 0);
    cyc("s5", 1, 1, 1, 0, 0, 0, 0, 0, 3, 0);
    cyc("s5rst", 0, 1, 1, 1, 1, 3, 1, 1, 0, 0);
    run1("s5rep");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
